// File: rtl/count_pkg.sv
// Shared types and helpers for the count_ud up/down counter.
// Holds the operation decode and the all-ones MAX helper.
package count_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_DEC  = 3'd2,
    OP_LD   = 3'd3,
    OP_CLR  = 3'd4
  } count_op_e;

  // Largest unsigned value representable in w bits (valid for w < 64).
  function automatic logic [63:0] max_of(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic count_op_e decode_op(input logic clr, input logic ld,
                                          input logic inc, input logic dec,
                                          input logic step_nz);
    count_op_e op;
    if (clr) begin
      op = OP_CLR;
    end else if (ld) begin
      op = OP_LD;
    end else if ((inc ^ dec) && step_nz) begin
      op = inc ? OP_INC : OP_DEC;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/count_step_alu.sv
// Combinational step arithmetic for count_ud: one step up or down with
// carry/borrow detection, saturating or wrapping at the range boundaries.
module count_step_alu
  import count_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  nxt,
  output logic              term,
  output logic              wrp
);

  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(max_of(WIDTH));

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign sum      = {1'b0, cur} + step_ext;
  assign diff     = {1'b0, cur} - step_ext;

  // Boundary handling: the extra top bit is the carry (up) or borrow (down).
  always_comb begin
    nxt  = cur;
    term = 1'b0;
    wrp  = 1'b0;
    if (up) begin
      if (sum[WIDTH]) begin
        if (sat_mode) begin
          nxt  = MAX[WIDTH-1:0];
          term = 1'b1;
        end else begin
          nxt = sum[WIDTH-1:0];
          wrp = 1'b1;
        end
      end else begin
        nxt  = sum[WIDTH-1:0];
        term = (sum == MAX);
      end
    end else begin
      if (diff[WIDTH]) begin
        if (sat_mode) begin
          nxt  = {WIDTH{1'b0}};
          term = 1'b1;
        end else begin
          nxt = diff[WIDTH-1:0];
          wrp = 1'b1;
        end
      end else begin
        nxt  = diff[WIDTH-1:0];
        term = (diff == {(WIDTH+1){1'b0}});
      end
    end
  end

endmodule

// File: rtl/count_ud.sv
// Loadable up/down counter with programmable step, wrap/saturate modes,
// auto-reload on decrement, and registered terminal-count / wrap pulses.
module count_ud
  import count_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter int              STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [WIDTH-1:0]  din,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              auto_rl,
  output logic [WIDTH-1:0]  dout,
  output logic              zero,
  output logic              tc,
  output logic              wrap
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;

  count_op_e        op_s;
  logic [WIDTH-1:0] alu_nxt_s;
  logic             alu_term_s;
  logic             alu_wrp_s;
  logic             rl_hit_s;

  assign op_s     = decode_op(clr, ld, inc, dec, (step != {STEP_W{1'b0}}));
  assign rl_hit_s = auto_rl &&
                    ({1'b0, dout_q} <= {{(WIDTH+1-STEP_W){1'b0}}, step});

  count_step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_alu (
    .cur      (dout_q),
    .step     (step),
    .up       (op_s == OP_INC),
    .sat_mode (sat_mode),
    .nxt      (alu_nxt_s),
    .term     (alu_term_s),
    .wrp      (alu_wrp_s)
  );

  // Next-state selection in priority order clr > ld > count > hold.
  always_comb begin
    dout_d = dout_q;
    rl_d   = rl_q;
    tc_d   = 1'b0;
    wrap_d = 1'b0;
    case (op_s)
      OP_CLR: begin
        dout_d = RESET_VAL;
        rl_d   = RESET_VAL;
      end
      OP_LD: begin
        dout_d = din;
        rl_d   = din;
      end
      OP_INC: begin
        dout_d = alu_nxt_s;
        tc_d   = alu_term_s;
        wrap_d = alu_wrp_s;
      end
      OP_DEC: begin
        // Auto-reload takes over before the counter can reach or pass zero.
        if (rl_hit_s) begin
          dout_d = rl_q;
          tc_d   = 1'b1;
        end else begin
          dout_d = alu_nxt_s;
          tc_d   = alu_term_s;
          wrap_d = alu_wrp_s;
        end
      end
      OP_HOLD: begin
        dout_d = dout_q;
      end
      default: begin
        dout_d = dout_q;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= RESET_VAL;
      rl_q   <= RESET_VAL;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rl_q   <= rl_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign dout = dout_q;
  assign zero = (dout_q == {WIDTH{1'b0}});
  assign tc   = tc_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_ud.sv
// Self-checking bench for count_ud (WIDTH=16, STEP_W=4, RESET_VAL=0):
// directed scenarios followed by random traffic against an integer model.
module tb_count_ud;

  localparam int MAXV = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [15:0] din = 16'd0;
  logic [3:0]  step = 4'd0;
  logic        sat_mode = 1'b0, auto_rl = 1'b0;
  logic [15:0] dout;
  logic        zero, tc, wrap;

  int errors = 0;
  int checks = 0;

  // Reference state
  int m_dout = 0;
  int m_rl   = 0;
  bit m_tc   = 1'b0;
  bit m_wrap = 1'b0;

  count_ud #(.WIDTH(16), .STEP_W(4), .RESET_VAL(16'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .din(din),
    .inc(inc), .dec(dec), .step(step), .sat_mode(sat_mode),
    .auto_rl(auto_rl), .dout(dout), .zero(zero), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, {16'd0, dout}, m_dout);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, (m_dout == 0)});
    check({tag, ".tc"},   {31'd0, tc},   {31'd0, m_tc});
    check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, m_wrap});
    check({tag, ".excl"}, {31'd0, (tc & wrap)}, 32'd0);
  endtask

  // Drive one cycle of inputs, predict the result, clock it, then check.
  task automatic cyc(input string tag, input bit c, input bit l, input int d,
                     input bit i, input bit de, input int s, input bit sm, input bit ar);
    int nd, v;
    bit nt, nw;
    clr = c; ld = l; din = d[15:0]; inc = i; dec = de;
    step = s[3:0]; sat_mode = sm; auto_rl = ar;
    nd = m_dout; nt = 1'b0; nw = 1'b0;
    if (c) begin
      nd = 0; m_rl = 0;
    end else if (l) begin
      nd = d; m_rl = d;
    end else if ((i != de) && s != 0) begin
      if (i) begin
        v = m_dout + s;
        if (v < MAXV) nd = v;
        else if (v == MAXV || sm) begin nd = MAXV; nt = 1'b1; end
        else begin nd = v - (MAXV + 1); nw = 1'b1; end
      end else if (ar && m_dout <= s) begin
        nd = m_rl; nt = 1'b1;
      end else begin
        v = m_dout - s;
        if (v > 0) nd = v;
        else if (v == 0 || sm) begin nd = 0; nt = 1'b1; end
        else begin nd = v + (MAXV + 1); nw = 1'b1; end
      end
    end
    @(posedge clk);
    m_dout = nd; m_tc = nt; m_wrap = nw;
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_dout = 0; m_rl = 0; m_tc = 1'b0; m_wrap = 1'b0;
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 10, dec by 3 saturating: 7,4,1,0 with tc on 0
    cyc("ld10", 1'b0, 1'b1, 10, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc("dec_sat", 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    check("dec_sat.final", {16'd0, dout}, 32'h0000);
    check("dec_sat.tc", {31'd0, tc}, 32'd1);
    // Sticky tc at zero in saturate mode
    cyc("dec_sat0", 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    check("dec_sat0.tc", {31'd0, tc}, 32'd1);

    // Same sequence wrapping
    cyc("ld10w", 1'b0, 1'b1, 10, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc("dec_wrap", 1'b0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    check("dec_wrap.final", {16'd0, dout}, 32'hFFFE);
    check("dec_wrap.wrap", {31'd0, wrap}, 32'd1);

    // Increment to MAX, then saturate, then wrap
    cyc("ldFFFD", 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    cyc("inc_max", 1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    check("inc_max.tc", {31'd0, tc}, 32'd1);
    cyc("inc_sat", 1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    check("inc_sat.dout", {16'd0, dout}, 32'hFFFF);
    cyc("inc_wrap", 1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check("inc_wrap.dout", {16'd0, dout}, 32'h0001);
    check("inc_wrap.wrap", {31'd0, wrap}, 32'd1);

    // Auto-reload: 5,4,3,2,1,5,... never zero
    cyc("ld5", 1'b0, 1'b1, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cyc("autorl", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
      check("autorl.nozero", {31'd0, zero}, 32'd0);
    end

    // Priority and conflicts
    cyc("ld_inc", 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    check("ld_inc.dout", {16'd0, dout}, 32'h1234);
    cyc("clr_ld", 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    check("clr_ld.dout", {16'd0, dout}, 32'h0000);
    cyc("ld_7", 1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc("incdec", 1'b0, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    check("incdec.dout", {16'd0, dout}, 32'd7);
    cyc("step0", 1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    check("step0.dout", {16'd0, dout}, 32'd7);

    // Reset mid-count, pulse pending
    cyc("ld2", 1'b0, 1'b1, 2, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    cyc("dec2", 1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    apply_reset("midreset");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int d;
      bit c, l, i, de, sm, ar;
      c  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 11) == 0);
      i  = $urandom_range(0, 1);
      de = $urandom_range(0, 1);
      sm = $urandom_range(0, 1);
      ar = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20))
                                        : int'($urandom_range(65515, 65535));
      cyc("rand", c, l, d, i, de, int'($urandom_range(0, 15)), sm, ar);
      if (n == 300) apply_reset("randreset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_ud.md
Name: count_ud

Overview:
- Parametrised successor to the multiplier datapath's 16-bit load/decrement counter.
- Loadable up/down counter with:
  - programmable step;
  - wrap or saturate on overflow;
  - optional auto-reload from a captured reload value;
  - zero, terminal-count and wrap flags.
- Used as the iteration/operand counter in the multiplier controller and in later sequencers.
- Replaces the fixed-width count-down block.

Parameters:
- WIDTH, 16: counter width in bits.
- STEP_W, 4: width of the step input.
- RESET_VAL, 0: value loaded into dout and the reload register on reset and clr.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear to RESET_VAL
- ld  in  1  load din into dout and the reload register
- din  in  WIDTH  load value
- inc  in  1  count up by step
- dec  in  1  count down by step
- step  in  STEP_W  step magnitude, unsigned, zero-extended to WIDTH
- sat_mode  in  1  1 = saturate at 0/MAX, 0 = wrap modulo 2^WIDTH
- auto_rl  in  1  1 = on decrement reaching or crossing 0, reload instead
- dout  out  WIDTH  counter value, registered
- zero  out  1  dout == 0, combinational from dout
- tc  out  1  one-cycle terminal-count pulse, registered
- wrap  out  1  one-cycle wrap pulse, registered

Behaviour:
- One clock domain; clk is the only clock. All state updates on posedge clk, except asynchronous reset.
- Reset (rst_n low, asynchronous):
  - dout = RESET_VAL, rl_q = RESET_VAL, tc = 0, wrap = 0.
  - zero follows dout.
  - Deassertion is synchronous to the design's reset synchroniser; no reset sync inside the block.
- MAX = 2^WIDTH - 1. Arithmetic is done in WIDTH+1 bits to detect carry/borrow.
- Priority per cycle: clr > ld > count > hold.
- clr: dout <= RESET_VAL, rl_q <= RESET_VAL, tc <= 0, wrap <= 0.
- ld: dout <= din, rl_q <= din, tc <= 0, wrap <= 0. inc/dec are ignored that cycle.
- Count active = inc XOR dec, and step != 0.
  - inc=dec=1, or step=0: hold dout; tc <= 0, wrap <= 0.
- Increment, sum = dout + step:
  - sum < MAX: dout <= sum, tc <= 0.
  - sum == MAX: dout <= MAX, tc <= 1.
  - sum > MAX, sat_mode=1: dout <= MAX, tc <= 1, wrap <= 0.
  - sum > MAX, sat_mode=0: dout <= sum mod 2^WIDTH, tc <= 0, wrap <= 1.
  - auto_rl has no effect on increment.
- Decrement, auto_rl=1 and dout <= step: dout <= rl_q, tc <= 1, wrap <= 0. The counter never reaches 0 by decrement in this mode.
- Decrement otherwise:
  - dout > step: dout <= dout - step, tc <= 0.
  - dout == step: dout <= 0, tc <= 1.
  - dout < step, sat_mode=1: dout <= 0, tc <= 1, wrap <= 0.
  - dout < step, sat_mode=0: dout <= (dout - step) mod 2^WIDTH, tc <= 0, wrap <= 1.
- Pulses: tc and wrap are high exactly one cycle after the causing edge. They are never high together. Both are 0 on any cycle without a qualifying event.
- Decrement on dout=0 with sat_mode=1 and auto_rl=0: dout stays 0, tc <= 1 every such cycle. The controller relies on this.
- Latency: dout and the flags reflect an operation one clock after it is sampled. zero has no additional delay relative to dout.
- Reset mid-count: immediate return to reset state. Any pending pulse is dropped.

Decomposition:
- Shared package count_pkg:
  - count_op_e enum (OP_HOLD, OP_INC, OP_DEC, OP_LD, OP_CLR), decoded from the control inputs.
  - Localparam helper for MAX.
- One natural sub-module: count_step_alu. Combinational. Takes dout, step, direction and sat_mode. Returns next value, a terminal flag and a wrap flag. It keeps the width/boundary arithmetic separately testable.
- The top holds dout, rl_q, tc, wrap and the priority decode.

Test Plan:
- Reset, WIDTH=16, RESET_VAL=0: rst_n low mid-count -> dout=0, zero=1, tc=0, wrap=0 immediately, without a clock edge.
- Load and step down: ld din=10, then dec with step=3 for 4 cycles, sat_mode=1 -> dout 10, 7, 4, 1, 0; tc pulses on the cycle dout becomes 0.
- Wrap down: same sequence with sat_mode=0 -> dout 10, 7, 4, 1, 0xFFFE; wrap pulses once on the 0xFFFE cycle, tc stays 0.
- Increment saturate/wrap: ld 0xFFFD, inc step=2 -> 0xFFFF with tc=1; next inc with sat_mode=1 -> 0xFFFF, tc=1; with sat_mode=0 -> 0x0001, wrap=1.
- Auto-reload: ld 5, auto_rl=1, dec step=1 continuously -> 5, 4, 3, 2, 1, 5, 4, ...; tc pulses every 5th cycle, and zero is never asserted.
- Priority and conflicts: ld with inc=1 -> loads din; clr with ld -> RESET_VAL; inc=dec=1 -> hold; step=0 -> hold with no pulses.
